// File: rtl/riscv_dpu_types_pkg.sv
// Shared types for the DPU responder: opcodes, FSM states, request and
// response structures, plus a population-count helper.
// Optional feature macro: RISCV_DPU_MUL_EN (enables opcode DPU_OP_MUL).
package riscv_dpu_types_pkg;

    localparam logic [6:0] DPU_OP_WRITE  = 7'h01;
    localparam logic [6:0] DPU_OP_READ   = 7'h02;
    localparam logic [6:0] DPU_OP_ADD    = 7'h03;
    localparam logic [6:0] DPU_OP_POPCNT = 7'h04;
    localparam logic [6:0] DPU_OP_CLR    = 7'h05;
    localparam logic [6:0] DPU_OP_MUL    = 7'h06;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } dpu_state_e;

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [31:0] data;
        logic [31:0] addr;
    } dpu_req_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic        error;
    } dpu_rsp_t;

    // Number of set bits in a 32-bit word.
    function automatic logic [31:0] popcount32(input logic [31:0] value);
        logic [5:0] count;
        count = 6'd0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, value[i]};
        end
        return {26'd0, count};
    endfunction

endpackage

// File: rtl/riscv_dpu_alu.sv
// Combinational operation unit for the DPU responder. Produces the response
// word, the error flag and the register-file write controls for one request.
// Optional feature macro: RISCV_DPU_MUL_EN (adds the MUL opcode).
module riscv_dpu_alu
    import riscv_dpu_types_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic [6:0]  opcode_i,
    input  logic [31:0] operand_i,
    input  logic [31:0] reg_val_i,
    input  logic [31:0] addr_i,
    output logic [31:0] result_o,
    output logic        error_o,
    output logic        reg_we_o,
    output logic        clr_all_o
);

    // Register window ends at NUM_REGS words; compared on 33 bits so the
    // limit itself is representable for any legal NUM_REGS.
    localparam logic [32:0] ADDR_LIMIT = 33'(NUM_REGS * 4);

    logic addr_ok_s;

    assign addr_ok_s = (addr_i[1:0] == 2'b00) && ({1'b0, addr_i} < ADDR_LIMIT);

`ifdef RISCV_DPU_MUL_EN
    logic [31:0] mul_s;

    // Only the low word of the product is ever kept.
    assign mul_s = reg_val_i * operand_i;
`endif

    // Decode the opcode into a result plus register update intent.
    always_comb begin
        result_o  = 32'd0;
        error_o   = 1'b0;
        reg_we_o  = 1'b0;
        clr_all_o = 1'b0;
        case (opcode_i)
            DPU_OP_WRITE: begin
                if (addr_ok_s) begin
                    result_o = operand_i;
                    reg_we_o = 1'b1;
                end else begin
                    error_o = 1'b1;
                end
            end
            DPU_OP_READ: begin
                if (addr_ok_s) begin
                    result_o = reg_val_i;
                end else begin
                    error_o = 1'b1;
                end
            end
            DPU_OP_ADD: begin
                if (addr_ok_s) begin
                    result_o = reg_val_i + operand_i;
                    reg_we_o = 1'b1;
                end else begin
                    error_o = 1'b1;
                end
            end
            DPU_OP_POPCNT: begin
                result_o = popcount32(operand_i);
            end
            DPU_OP_CLR: begin
                clr_all_o = 1'b1;
            end
`ifdef RISCV_DPU_MUL_EN
            DPU_OP_MUL: begin
                if (addr_ok_s) begin
                    result_o = mul_s;
                    reg_we_o = 1'b1;
                end else begin
                    error_o = 1'b1;
                end
            end
`endif
            default: begin
                error_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_dpu_responder.sv
// DPU request/response responder: a three-state FSM (IDLE, EXEC, RESP) in
// front of a small scratch register file. One request in flight at a time;
// register updates commit on the EXEC->RESP edge together with the
// registered response.
// Optional feature macro: RISCV_DPU_MUL_EN (4-cycle MUL via a down-counter).
module riscv_dpu_responder
    import riscv_dpu_types_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  dpu_req_t dpu_req_i,
    output logic     dpu_req_ready_o,
    output dpu_rsp_t dpu_rsp_o,
    input  logic     dpu_rsp_ready_i
);

    localparam int IDX_W = $clog2(NUM_REGS);

    dpu_state_e  state_q, state_d;
    logic [6:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [31:0] addr_q, addr_d;
    dpu_rsp_t    rsp_q, rsp_d;
    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    logic [IDX_W-1:0] idx_s;
    logic [31:0]      alu_result_s;
    logic             alu_error_s;
    logic             alu_we_s;
    logic             alu_clr_s;
    logic             exec_done_s;

`ifdef RISCV_DPU_MUL_EN
    logic [1:0] mul_cnt_q, mul_cnt_d;

    // MUL stays in EXEC until the counter has walked down to zero.
    assign exec_done_s = (mul_cnt_q == 2'd0);
`else
    assign exec_done_s = 1'b1;
`endif

    assign idx_s           = addr_q[IDX_W+1:2];
    assign dpu_req_ready_o = (state_q == IDLE);
    assign dpu_rsp_o       = rsp_q;

    riscv_dpu_alu #(
        .NUM_REGS (NUM_REGS)
    ) u_alu (
        .opcode_i  (op_q),
        .operand_i (data_q),
        .reg_val_i (regs_q[idx_s]),
        .addr_i    (addr_q),
        .result_o  (alu_result_s),
        .error_o   (alu_error_s),
        .reg_we_o  (alu_we_s),
        .clr_all_o (alu_clr_s)
    );

    // Next-state, request latch, register file and response computation.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        addr_d  = addr_q;
        rsp_d   = rsp_q;
        regs_d  = regs_q;
`ifdef RISCV_DPU_MUL_EN
        mul_cnt_d = mul_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (dpu_req_i.valid) begin
                    op_d    = dpu_req_i.opcode;
                    data_d  = dpu_req_i.data;
                    addr_d  = dpu_req_i.addr;
                    state_d = EXEC;
`ifdef RISCV_DPU_MUL_EN
                    if (dpu_req_i.opcode == DPU_OP_MUL) begin
                        mul_cnt_d = 2'd3;
                    end else begin
                        mul_cnt_d = 2'd0;
                    end
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                if (exec_done_s) begin
                    state_d     = RESP;
                    rsp_d.valid = 1'b1;
                    rsp_d.data  = alu_result_s;
                    rsp_d.error = alu_error_s;
                    if (alu_clr_s) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            regs_d[i] = 32'd0;
                        end
                    end else if (alu_we_s) begin
                        regs_d[idx_s] = alu_result_s;
                    end else begin
                        regs_d = regs_q;
                    end
                end else begin
                    state_d = EXEC;
`ifdef RISCV_DPU_MUL_EN
                    mul_cnt_d = mul_cnt_q - 2'd1;
`endif
                end
            end
            RESP: begin
                if (dpu_rsp_ready_i) begin
                    state_d     = IDLE;
                    rsp_d.valid = 1'b0;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
                rsp_d   = '0;
            end
        endcase
    end

    // State, request latch, register file and response flops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= 7'd0;
            data_q  <= 32'd0;
            addr_q  <= 32'd0;
            rsp_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 32'd0;
            end
`ifdef RISCV_DPU_MUL_EN
            mul_cnt_q <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            rsp_q   <= rsp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
`ifdef RISCV_DPU_MUL_EN
            mul_cnt_q <= mul_cnt_d;
`endif
        end
    end

endmodule
